// File: rtl/alu_pkg.sv
// Shared opcode, SFR address and STATUS bit definitions for the PIC16F84-style ALU.
package alu_pkg;

    localparam logic [6:0] INDF_ADDR   = 7'h00;
    localparam logic [6:0] STATUS_ADDR = 7'h03;
    localparam logic [6:0] FSR_ADDR    = 7'h04;
    localparam logic [6:0] GPR_ADDR    = 7'h0C;

    localparam int C_BIT   = 0;
    localparam int DC_BIT  = 1;
    localparam int Z_BIT   = 2;
    localparam int RP0_BIT = 5;
    localparam int IRP_BIT = 7;

    localparam logic [1:0] CLS_BYTE = 2'b00;
    localparam logic [1:0] CLS_BIT  = 2'b01;
    localparam logic [1:0] CLS_LIT  = 2'b11;

    localparam logic [3:0] OP_NOP_MOVWF = 4'b0000;
    localparam logic [3:0] OP_CLR       = 4'b0001;
    localparam logic [3:0] OP_SUBWF     = 4'b0010;
    localparam logic [3:0] OP_DECF      = 4'b0011;
    localparam logic [3:0] OP_IORWF     = 4'b0100;
    localparam logic [3:0] OP_ANDWF     = 4'b0101;
    localparam logic [3:0] OP_XORWF     = 4'b0110;
    localparam logic [3:0] OP_ADDWF     = 4'b0111;
    localparam logic [3:0] OP_MOVF      = 4'b1000;
    localparam logic [3:0] OP_COMF      = 4'b1001;
    localparam logic [3:0] OP_INCF      = 4'b1010;
    localparam logic [3:0] OP_DECFSZ    = 4'b1011;
    localparam logic [3:0] OP_RRF       = 4'b1100;
    localparam logic [3:0] OP_RLF       = 4'b1101;
    localparam logic [3:0] OP_SWAPF     = 4'b1110;
    localparam logic [3:0] OP_INCFSZ    = 4'b1111;

    localparam logic [1:0] BOP_BCF = 2'b00;
    localparam logic [1:0] BOP_BSF = 2'b01;

    localparam logic [3:0] LOP_MOVLW = 4'b00??;
    localparam logic [3:0] LOP_RETLW = 4'b01??;
    localparam logic [3:0] LOP_IORLW = 4'b1000;
    localparam logic [3:0] LOP_ANDLW = 4'b1001;
    localparam logic [3:0] LOP_XORLW = 4'b1010;
    localparam logic [3:0] LOP_SUBLW = 4'b110?;
    localparam logic [3:0] LOP_ADDLW = 4'b111?;

    typedef struct packed {
        logic [7:0] res;
        logic       wr_w;
        logic       wr_f;
        logic       upd_c;
        logic       upd_dc;
        logic       upd_z;
        logic       c;
        logic       dc;
        logic       z;
    } dp_out_t;

    // Every implemented location is mirrored, so the bank bit never picks storage.
    function automatic logic is_gpr(input logic [6:0] a);
        return a == 7'h02 || a == FSR_ADDR || (a >= 7'h0A && a <= 7'h4F);
    endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational result and flag computation for one PIC16F84 instruction word.
module alu_datapath
    import alu_pkg::*;
(
    input  logic [13:0] op,
    input  logic [7:0]  w,
    input  logic [7:0]  f,
    input  logic        c_in,
    output dp_out_t     dp
);

    logic       is_byte;
    logic       is_bit;
    logic       is_lit;
    logic       d;
    logic [7:0] k;
    logic [7:0] src;
    logic [7:0] mask;
    logic [8:0] add;
    logic [8:0] sub;
    logic [4:0] add_lo;
    logic [4:0] sub_lo;

    assign is_byte = op[13:12] == CLS_BYTE;
    assign is_bit  = op[13:12] == CLS_BIT;
    assign is_lit  = op[13:12] == CLS_LIT;
    assign d       = op[7];
    assign k       = op[7:0];
    assign src     = is_lit ? k : f;
    assign mask    = 8'h01 << op[9:7];

    // Subtraction is src + ~w + 1, so carry out means "no borrow".
    assign add    = {1'b0, src} + {1'b0, w};
    assign sub    = {1'b0, src} + {1'b0, ~w} + 9'd1;
    assign add_lo = {1'b0, src[3:0]} + {1'b0, w[3:0]};
    assign sub_lo = {1'b0, src[3:0]} + {1'b0, ~w[3:0]} + 5'd1;

    always_comb begin
        dp = '0;
        unique case (1'b1)
            is_byte: begin
                dp.wr_w = ~d;
                dp.wr_f = d;
                unique case (op[11:8])
                    OP_NOP_MOVWF: begin
                        dp.res  = w;
                        dp.wr_w = 1'b0;
                    end
                    OP_CLR: begin
                        dp.res   = 8'h00;
                        dp.upd_z = 1'b1;
                    end
                    OP_SUBWF: begin
                        dp.res    = sub[7:0];
                        dp.c      = sub[8];
                        dp.dc     = sub_lo[4];
                        dp.upd_c  = 1'b1;
                        dp.upd_dc = 1'b1;
                        dp.upd_z  = 1'b1;
                    end
                    OP_ADDWF: begin
                        dp.res    = add[7:0];
                        dp.c      = add[8];
                        dp.dc     = add_lo[4];
                        dp.upd_c  = 1'b1;
                        dp.upd_dc = 1'b1;
                        dp.upd_z  = 1'b1;
                    end
                    OP_DECF: begin
                        dp.res   = f - 8'd1;
                        dp.upd_z = 1'b1;
                    end
                    OP_INCF: begin
                        dp.res   = f + 8'd1;
                        dp.upd_z = 1'b1;
                    end
                    OP_IORWF: begin
                        dp.res   = f | w;
                        dp.upd_z = 1'b1;
                    end
                    OP_ANDWF: begin
                        dp.res   = f & w;
                        dp.upd_z = 1'b1;
                    end
                    OP_XORWF: begin
                        dp.res   = f ^ w;
                        dp.upd_z = 1'b1;
                    end
                    OP_MOVF: begin
                        dp.res   = f;
                        dp.upd_z = 1'b1;
                    end
                    OP_COMF: begin
                        dp.res   = ~f;
                        dp.upd_z = 1'b1;
                    end
                    OP_RRF: begin
                        dp.res   = {c_in, f[7:1]};
                        dp.c     = f[0];
                        dp.upd_c = 1'b1;
                    end
                    OP_RLF: begin
                        dp.res   = {f[6:0], c_in};
                        dp.c     = f[7];
                        dp.upd_c = 1'b1;
                    end
                    OP_DECFSZ: dp.res = f - 8'd1;
                    OP_INCFSZ: dp.res = f + 8'd1;
                    OP_SWAPF:  dp.res = {f[3:0], f[7:4]};
                    default:   dp.res = f;
                endcase
            end
            is_bit: begin
                dp.res = f;
                unique case (op[11:10])
                    BOP_BCF: begin
                        dp.res  = f & ~mask;
                        dp.wr_f = 1'b1;
                    end
                    BOP_BSF: begin
                        dp.res  = f | mask;
                        dp.wr_f = 1'b1;
                    end
                    default: ;
                endcase
            end
            is_lit: begin
                dp.wr_w = 1'b1;
                unique casez (op[11:8])
                    LOP_MOVLW, LOP_RETLW: dp.res = k;
                    LOP_IORLW: begin
                        dp.res   = k | w;
                        dp.upd_z = 1'b1;
                    end
                    LOP_ANDLW: begin
                        dp.res   = k & w;
                        dp.upd_z = 1'b1;
                    end
                    LOP_XORLW: begin
                        dp.res   = k ^ w;
                        dp.upd_z = 1'b1;
                    end
                    LOP_SUBLW: begin
                        dp.res    = sub[7:0];
                        dp.c      = sub[8];
                        dp.dc     = sub_lo[4];
                        dp.upd_c  = 1'b1;
                        dp.upd_dc = 1'b1;
                        dp.upd_z  = 1'b1;
                    end
                    LOP_ADDLW: begin
                        dp.res    = add[7:0];
                        dp.c      = add[8];
                        dp.dc     = add_lo[4];
                        dp.upd_c  = 1'b1;
                        dp.upd_dc = 1'b1;
                        dp.upd_z  = 1'b1;
                    end
                    default: dp.wr_w = 1'b0;
                endcase
            end
            default: ;
        endcase
        dp.z = dp.res == 8'h00;
    end

endmodule

// File: rtl/alu.sv
// PIC16F84-style ALU: W, STATUS and file registers, one instruction per clock.
// Define ALU_INDF_EN to make address 0x00 (INDF) access the register FSR points at.
module alu
    import alu_pkg::*;
#(
    parameter logic [7:0] GPR_INIT = 8'h95,
    parameter logic [7:0] FSR_INIT = 8'h89
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] OP_CODE,
    output logic [7:0]  W_REG,
    output logic [7:0]  STATUS_REG,
    output logic [7:0]  CHECK_REG,
    output logic [7:0]  BANK1
);

    logic [7:0] w_q;
    logic [7:0] status_q;
    logic [7:0] st_nx;
    logic [7:0] mem [128];
    logic [7:0] f_val;
    logic [6:0] fa;
    dp_out_t    dp;

    always_comb begin
        fa = OP_CODE[6:0];
`ifdef ALU_INDF_EN
        // IRP only names a bank, and every location is mirrored across banks.
        if (fa == INDF_ADDR) fa = mem[FSR_ADDR][6:0];
`endif
    end

    always_comb begin
        f_val = 8'h00;
        if (fa == STATUS_ADDR) f_val = status_q;
        else if (is_gpr(fa))   f_val = mem[fa];
    end

    alu_datapath u_dp (
        .op   (OP_CODE),
        .w    (w_q),
        .f    (f_val),
        .c_in (status_q[C_BIT]),
        .dp   (dp)
    );

    // Flag updates take priority over a direct write of STATUS.
    always_comb begin
        st_nx = status_q;
        if (dp.wr_f && fa == STATUS_ADDR) st_nx = dp.res;
        if (dp.upd_c)  st_nx[C_BIT]  = dp.c;
        if (dp.upd_dc) st_nx[DC_BIT] = dp.dc;
        if (dp.upd_z)  st_nx[Z_BIT]  = dp.z;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q      <= 8'h00;
            status_q <= 8'h18;
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            mem[FSR_ADDR] <= FSR_INIT;
            mem[GPR_ADDR] <= GPR_INIT;
        end else begin
            status_q <= st_nx;
            if (dp.wr_w) w_q <= dp.res;
            if (dp.wr_f && is_gpr(fa)) mem[fa] <= dp.res;
        end
    end

    assign W_REG      = w_q;
    assign STATUS_REG = status_q;
    assign CHECK_REG  = f_val;
    assign BANK1      = mem[FSR_ADDR];

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random instruction words
// checked against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [13:0] OP_CODE;
    logic [7:0]  W_REG;
    logic [7:0]  STATUS_REG;
    logic [7:0]  CHECK_REG;
    logic [7:0]  BANK1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mw;
    logic [7:0] mst;
    logic [7:0] mf [128];

    alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .OP_CODE    (OP_CODE),
        .W_REG      (W_REG),
        .STATUS_REG (STATUS_REG),
        .CHECK_REG  (CHECK_REG),
        .BANK1      (BANK1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    function automatic bit m_impl(input int a);
        return a == 2 || a == 4 || (a >= 10 && a <= 79);
    endfunction

    function automatic int m_res(input logic [6:0] a);
`ifdef ALU_INDF_EN
        if (a == 7'd0) return int'(mf[4] % 128);
`endif
        return int'(a);
    endfunction

    function automatic int m_rd(input logic [6:0] a0);
        int a;
        a = m_res(a0);
        if (a == 3) return int'(mst);
        if (m_impl(a)) return int'(mf[a]);
        return 0;
    endfunction

    task automatic m_reset();
        mw  = 8'h00;
        mst = 8'h18;
        for (int i = 0; i < 128; i++) mf[i] = 8'h00;
        mf[4]  = 8'h89;
        mf[12] = 8'h95;
    endtask

    task automatic m_exec(input logic [13:0] op);
        int a, f, k, r, cls, sel, bitn, nc, ndc, wv;
        bit to_w, to_f, fz, fc, fdc;
        a = m_res(op[6:0]);
        f = m_rd(op[6:0]);
        k = int'(op[7:0]);
        wv = int'(mw);
        cls = int'(op[13:12]);
        sel = int'(op[11:8]);
        bitn = int'(op[9:7]);
        nc = int'(mst[0]);
        ndc = int'(mst[1]);
        r = 0;
        to_w = 0; to_f = 0; fz = 0; fc = 0; fdc = 0;
        if (cls == 0) begin
            to_w = !op[7];
            to_f = op[7];
            case (sel)
                0: begin r = wv; to_w = 0; end
                1: begin r = 0; fz = 1; end
                2: begin
                    r = f - wv; nc = int'(f >= wv);
                    ndc = int'(f % 16 >= wv % 16);
                    fz = 1; fc = 1; fdc = 1;
                end
                3: begin r = f - 1; fz = 1; end
                4: begin r = f | wv; fz = 1; end
                5: begin r = f & wv; fz = 1; end
                6: begin r = f ^ wv; fz = 1; end
                7: begin
                    r = f + wv; nc = int'(r > 255);
                    ndc = int'(f % 16 + wv % 16 > 15);
                    fz = 1; fc = 1; fdc = 1;
                end
                8: begin r = f; fz = 1; end
                9: begin r = 255 - f; fz = 1; end
                10: begin r = f + 1; fz = 1; end
                11: r = f - 1;
                12: begin r = f / 2 + int'(mst[0]) * 128; nc = f % 2; fc = 1; end
                13: begin r = f * 2 + int'(mst[0]); nc = f / 128; fc = 1; end
                14: r = (f % 16) * 16 + f / 16;
                default: r = f + 1;
            endcase
        end else if (cls == 1) begin
            if (op[11:10] == 2'b00) begin r = f & ~(1 << bitn); to_f = 1; end
            if (op[11:10] == 2'b01) begin r = f | (1 << bitn); to_f = 1; end
        end else if (cls == 3) begin
            to_w = 1;
            if (sel < 8) r = k;
            else case (sel)
                8: begin r = k | wv; fz = 1; end
                9: begin r = k & wv; fz = 1; end
                10: begin r = k ^ wv; fz = 1; end
                12, 13: begin
                    r = k - wv; nc = int'(k >= wv);
                    ndc = int'(k % 16 >= wv % 16);
                    fz = 1; fc = 1; fdc = 1;
                end
                14, 15: begin
                    r = k + wv; nc = int'(r > 255);
                    ndc = int'(k % 16 + wv % 16 > 15);
                    fz = 1; fc = 1; fdc = 1;
                end
                default: to_w = 0;
            endcase
        end
        r = r & 255;
        if (to_f) begin
            if (a == 3) mst = r[7:0];
            else if (m_impl(a)) mf[a] = r[7:0];
        end
        if (to_w) mw = r[7:0];
        if (fc) mst[0] = nc[0];
        if (fdc) mst[1] = ndc[0];
        if (fz) mst[2] = (r == 0);
    endtask

    task automatic exec(input logic [13:0] op);
        @(negedge clk);
        OP_CODE = op;
        @(posedge clk);
        #1;
        m_exec(op);
        chk("w", W_REG, mw);
        chk("status", STATUS_REG, mst);
        chk("bank1", BANK1, mf[4]);
    endtask

    // BTFSC is a no-op, so it exposes CHECK_REG without changing state.
    task automatic probe(input logic [6:0] a, input logic [7:0] exp);
        OP_CODE = 14'h1800 | {7'd0, a};
        #1;
        chk("check_reg", CHECK_REG, exp);
        chk("check_model", CHECK_REG, m_rd(a) & 255);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        OP_CODE = 14'($urandom_range(0, 16383));
        @(posedge clk);
        #1;
        m_reset();
        chk("rst_w", W_REG, 8'h00);
        chk("rst_status", STATUS_REG, 8'h18);
        chk("rst_fsr", BANK1, 8'h89);
        @(negedge clk);
        rst_n = 1'b1;
        OP_CODE = 14'h0000;
        probe(7'h0C, 8'h95);
    endtask

    logic [13:0] rop;
    logic [6:0]  ra;

    initial begin
        rst_n = 1'b0;
        OP_CODE = 14'h0000;
        do_reset();

        exec(14'h080C);
        chk("movf_w", W_REG, 8'h95);
        chk("movf_flags", {5'd0, STATUS_REG[2:0]}, 8'h00);
        exec(14'h078C);
        probe(7'h0C, 8'h2A);
        chk("addwf_flags", {5'd0, STATUS_REG[2:0]}, 8'h01);
        exec(14'h0504);
        chk("andwf_w", W_REG, 8'h81);
        chk("andwf_flags", {5'd0, STATUS_REG[2:0]}, 8'h01);
        exec(14'h018C);
        probe(7'h0C, 8'h00);
        chk("clrf_flags", {5'd0, STATUS_REG[2:0]}, 8'h05);
        exec(14'h30FF);
        exec(14'h008A);
        exec(14'h0A8A);
        probe(7'h0A, 8'h00);
        chk("incf_flags", {5'd0, STATUS_REG[2:0]}, 8'h05);
        exec(14'h3000);
        exec(14'h3C20);
        chk("sublw_w", W_REG, 8'h20);
        chk("sublw_flags", {5'd0, STATUS_REG[2:0]}, 8'h03);
        exec(14'h30EF);
        exec(14'h3E15);
        chk("addlw_w", W_REG, 8'h04);
        chk("addlw_flags", {5'd0, STATUS_REG[2:0]}, 8'h03);

        do_reset();
        exec(14'h1484);
        probe(7'h04, 8'h8B);
        chk("bsf_bank1", BANK1, 8'h8B);
        exec(14'h30EF);
        exec(14'h008C);
        exec(14'h100C);
        probe(7'h0C, 8'hEE);
        exec(14'h30FF);
        exec(14'h0084);
        exec(14'h0C84);
        probe(7'h04, 8'h7F);
        chk("rrf_flags", {5'd0, STATUS_REG[2:0]}, 8'h01);
        exec(14'h30FE);
        exec(14'h008C);
        exec(14'h0E0C);
        chk("swapf_w", W_REG, 8'hEF);
        chk("swapf_flags", {5'd0, STATUS_REG[2:0]}, 8'h01);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                rop = 14'($urandom_range(0, 16383));
                exec(rop);
                ra = 7'($urandom_range(0, 127));
                OP_CODE = 14'h1800 | {7'd0, ra};
                #1;
                chk("rand_check", CHECK_REG, m_rd(ra) & 255);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
